// File: rtl/x_mem_arbiter_pkg.sv
// rtl/x_mem_arbiter_pkg.sv - shared widths, types and helpers for the x-vector memory arbiter
package x_mem_arbiter_pkg;

    localparam int ADDR_WIDTH = 48;
    localparam int DATA_WIDTH = 64;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    // The controller works on 8-byte words, so the low address bits are always cleared.
    localparam addr_t ADDR_ALIGN_MASK = {{(ADDR_WIDTH-3){1'b1}}, 3'b000};

    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/x_mem_arbiter_fifo.sv
// rtl/x_mem_arbiter_fifo.sv - show-ahead FIFO (zero read latency) with registered almost-full
module x_mem_arbiter_fifo
    import x_mem_arbiter_pkg::*;
#(
    parameter int WIDTH       = 48,
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             afull,
    output logic             overflow
);

    localparam int PTR_W = log2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             afull_q, afull_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign afull = afull_q;
    assign rdata = mem_q[rd_ptr_q];

    // A push into a full FIFO is still accepted when the same cycle pops; pointers wrap (DEPTH is 2^n).
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        overflow = push && !do_push;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
        afull_d = (count_d >= CNT_W'(AFULL_LEVEL));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            afull_q  <= afull_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/x_mem_arbiter_rr.sv
// rtl/x_mem_arbiter_rr.sv - round-robin pick whose search starts just after the last winner
module x_mem_arbiter_rr
    import x_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = log2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id
);

    logic [ID_W-1:0] last_grant_q, last_grant_d;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = last_grant_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!gnt_valid && req[ID_W'((int'(last_grant_q) + i) % NUM_REQ)]) begin
                gnt_valid = 1'b1;
                gnt_id    = ID_W'((int'(last_grant_q) + i) % NUM_REQ);
            end
        end
        last_grant_d = (advance && gnt_valid) ? gnt_id : last_grant_q;
    end

    // Resetting to the highest id makes requester 0 the first winner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/x_mem_arbiter.sv
// rtl/x_mem_arbiter.sv - shares one memory-controller read port among NUM_REQ x-vector requesters
module x_mem_arbiter
    import x_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int LOG2_NUM_REQ    = 2,
    parameter int REQ_FIFO_DEPTH  = 16,
    parameter int MAX_OUTSTANDING = 64,
    parameter int AFULL_MARGIN    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_push,
    input  logic [ADDR_WIDTH*NUM_REQ-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_afull,
    output logic                          mem_req,
    output logic [ADDR_WIDTH-1:0]         mem_req_addr,
    input  logic                          mem_stall,
    input  logic                          mem_rsp_push,
    input  logic [DATA_WIDTH-1:0]         mem_rsp_q,
    output logic [NUM_REQ-1:0]            rsp_push,
    output logic [DATA_WIDTH-1:0]         rsp_q,
    output logic                          idle,
    output logic                          err
);

    localparam int OUT_W = log2(MAX_OUTSTANDING) + 1;

    logic [NUM_REQ-1:0]      req_empty, req_pop, req_overflow, req_full_unused;
    addr_t                   req_head [NUM_REQ];
    logic                    tag_empty, tag_full, tag_pop, tag_overflow, tag_afull_unused;
    logic [LOG2_NUM_REQ-1:0] tag_head, gnt_id;
    logic                    gnt_valid, grant, orphan;

    logic                    mem_req_q, mem_req_d;
    addr_t                   mem_req_addr_q, mem_req_addr_d;
    logic [NUM_REQ-1:0]      rsp_push_q, rsp_push_d;
    data_t                   rsp_q_q, rsp_q_d;
    logic [OUT_W-1:0]        out_cnt_q, out_cnt_d;
    logic                    err_q, err_d;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_fifo
        x_mem_arbiter_fifo #(
            .WIDTH       (ADDR_WIDTH),
            .DEPTH       (REQ_FIFO_DEPTH),
            .AFULL_LEVEL (REQ_FIFO_DEPTH - AFULL_MARGIN)
        ) u_req_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (req_push[g]),
            .wdata    (req_addr[ADDR_WIDTH*g +: ADDR_WIDTH]),
            .pop      (req_pop[g]),
            .rdata    (req_head[g]),
            .empty    (req_empty[g]),
            .full     (req_full_unused[g]),
            .afull    (req_afull[g]),
            .overflow (req_overflow[g])
        );
    end

    x_mem_arbiter_rr #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (LOG2_NUM_REQ)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (~req_empty),
        .advance   (grant),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Tag FIFO remembers the issuing requester of every in-flight read, in issue order.
    x_mem_arbiter_fifo #(
        .WIDTH (LOG2_NUM_REQ),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (grant),
        .wdata    (gnt_id),
        .pop      (tag_pop),
        .rdata    (tag_head),
        .empty    (tag_empty),
        .full     (tag_full),
        .afull    (tag_afull_unused),
        .overflow (tag_overflow)
    );

    // Fullness is sampled before this cycle's response pop, so a freed slot is reused one cycle later.
    assign grant  = gnt_valid && !mem_stall && !tag_full;
    assign tag_pop = mem_rsp_push && !tag_empty;
    assign orphan  = mem_rsp_push && tag_empty;

    always_comb begin
        req_pop = '0;
        if (grant) begin
            req_pop[gnt_id] = 1'b1;
        end

        mem_req_d      = grant;
        mem_req_addr_d = grant ? (req_head[gnt_id] & ADDR_ALIGN_MASK) : mem_req_addr_q;

        rsp_push_d = '0;
        if (tag_pop) begin
            rsp_push_d[tag_head] = 1'b1;
        end
        rsp_q_d = tag_pop ? mem_rsp_q : rsp_q_q;

        out_cnt_d = out_cnt_q;
        if (grant && !tag_pop) begin
            out_cnt_d = out_cnt_q + OUT_W'(1);
        end else if (tag_pop && !grant) begin
            out_cnt_d = out_cnt_q - OUT_W'(1);
        end

        err_d = err_q || (|req_overflow) || tag_overflow || orphan;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_q      <= 1'b0;
            mem_req_addr_q <= '0;
            rsp_push_q     <= '0;
            rsp_q_q        <= '0;
            out_cnt_q      <= '0;
            err_q          <= 1'b0;
        end else begin
            mem_req_q      <= mem_req_d;
            mem_req_addr_q <= mem_req_addr_d;
            rsp_push_q     <= rsp_push_d;
            rsp_q_q        <= rsp_q_d;
            out_cnt_q      <= out_cnt_d;
            err_q          <= err_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_req_addr = mem_req_addr_q;
    assign rsp_push     = rsp_push_q;
    assign rsp_q        = rsp_q_q;
    assign err          = err_q;
    assign idle         = (&req_empty) && tag_empty && (out_cnt_q == '0) && !mem_req_q;

endmodule

// File: tb/tb_x_mem_arbiter.sv
// tb/tb_x_mem_arbiter.sv - scoreboard bench for the x-vector memory arbiter
module tb_x_mem_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_push;
    logic [48*N-1:0] req_addr;
    logic [N-1:0]   req_afull;
    logic           mem_req;
    logic [47:0]    mem_req_addr;
    logic           mem_stall;
    logic           mem_rsp_push;
    logic [63:0]    mem_rsp_q;
    logic [N-1:0]   rsp_push;
    logic [63:0]    rsp_q;
    logic           idle;
    logic           err;

    x_mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_push     (req_push),
        .req_addr     (req_addr),
        .req_afull    (req_afull),
        .mem_req      (mem_req),
        .mem_req_addr (mem_req_addr),
        .mem_stall    (mem_stall),
        .mem_rsp_push (mem_rsp_push),
        .mem_rsp_q    (mem_rsp_q),
        .rsp_push     (rsp_push),
        .rsp_q        (rsp_q),
        .idle         (idle),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct { int id; logic [47:0] addr; } iss_t;
    typedef struct { logic [3:0] onehot; logic [63:0] data; } rsp_t;

    iss_t exp_iss[$];
    int   inflight[$];
    rsp_t exp_rsp[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected issue/response whenever the DUT presents one.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (mem_req) begin
                if (exp_iss.size() == 0) begin
                    chk("unexpected_mem_req", 64'(mem_req), 64'd0);
                end else begin
                    iss_t e;
                    e = exp_iss.pop_front();
                    chk("mem_req_addr", 64'(mem_req_addr), 64'(e.addr));
                    inflight.push_back(e.id);
                end
            end
            if (rsp_push != '0) begin
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rsp_push", 64'(rsp_push), 64'd0);
                end else begin
                    rsp_t r;
                    r = exp_rsp.pop_front();
                    chk("rsp_push", 64'(rsp_push), 64'(r.onehot));
                    chk("rsp_q", rsp_q, r.data);
                end
            end
        end
    end

    function automatic logic [47:0] addr_of(input int id, input int k, input int lo);
        return 48'h0000_A000_0000 + 48'(id << 12) + 48'(k << 4) + 48'(lo);
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_issue(input int id, input logic [47:0] addr);
        iss_t e;
        e.id   = id;
        e.addr = addr;
        exp_iss.push_back(e);
    endtask

    // Directed cases are arranged so that grant order equals ascending requester order per push cycle.
    task automatic pushv(input logic [3:0] mask, input int k, input int lo, input bit expect_it);
        for (int i = 0; i < N; i++) begin
            req_push[i] = mask[i];
            req_addr[48*i +: 48] = addr_of(i, k, lo);
            if (mask[i] && expect_it) exp_issue(i, addr_of(i, k, 0));
        end
        cycle();
        req_push = '0;
    endtask

    task automatic respond(input logic [63:0] data);
        mem_rsp_push = 1'b1;
        mem_rsp_q    = data;
        if (inflight.size() > 0) begin
            rsp_t r;
            int   id;
            id       = inflight.pop_front();
            r.onehot = 4'(1 << id);
            r.data   = data;
            exp_rsp.push_back(r);
        end
        cycle();
        mem_rsp_push = 1'b0;
    endtask

    task automatic drain(input logic [63:0] base);
        int guard;
        guard = 0;
        while ((inflight.size() > 0 || exp_iss.size() > 0 || exp_rsp.size() > 0) && guard < 300) begin
            if (inflight.size() > 0) respond(base + 64'(guard));
            else cycle();
            guard++;
        end
        cycle();
        cycle();
        chk("iss_left", 64'(exp_iss.size()), 64'd0);
        chk("rsp_left", 64'(exp_rsp.size()), 64'd0);
        chk("idle_after_drain", 64'(idle), 64'd1);
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        req_push     = '0;
        mem_stall    = 1'b0;
        mem_rsp_push = 1'b0;
        exp_iss.delete();
        inflight.delete();
        exp_rsp.delete();
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst          = 1'b0;
        req_push     = '0;
        req_addr     = '0;
        mem_stall    = 1'b0;
        mem_rsp_push = 1'b0;
        mem_rsp_q    = '0;
        repeat (2) cycle();
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_req_addr", 64'(mem_req_addr), 64'd0);
        chk("rst_rsp_push", 64'(rsp_push), 64'd0);
        chk("rst_rsp_q", rsp_q, 64'd0);
        chk("rst_req_afull", 64'(req_afull), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_err", 64'(err), 64'd0);
        rst = 1'b1;
        cycle();

        // Single request from requester 2
        req_push = 4'b0100;
        req_addr[2*48 +: 48] = 48'h1000;
        exp_issue(2, 48'h1000);
        cycle();
        req_push = '0;
        chk("single_lat_c1", 64'(mem_req), 64'd0);
        cycle();
        chk("single_lat_c2", 64'(mem_req), 64'd1);
        repeat (8) cycle();
        respond(64'hDEAD);
        chk("single_rsp_push", 64'(rsp_push), 64'h4);
        chk("single_rsp_q", rsp_q, 64'hDEAD);
        drain(64'h0);

        // Fairness: 3 requests from every requester, low address bits must be cleared
        do_reset();
        for (int k = 0; k < 3; k++) pushv(4'hF, k, 5, 1'b1);
        cnt = 0;
        for (int c = 0; c < 11; c++) begin
            if (mem_req) cnt++;
            cycle();
        end
        chk("fair_back_to_back", 64'(cnt), 64'd11);
        chk("fair_end", 64'(mem_req), 64'd0);
        drain(64'h100);

        // Stall for 5 cycles with loaded FIFOs
        do_reset();
        pushv(4'hF, 0, 0, 1'b1);
        pushv(4'hF, 1, 2, 1'b1);
        mem_stall = 1'b1;
        chk("stall_first_req", 64'(mem_req), 64'd1);
        cnt = 0;
        repeat (4) begin
            cycle();
            if (mem_req) cnt++;
        end
        cycle();
        mem_stall = 1'b0;
        if (mem_req) cnt++;
        chk("stall_quiet", 64'(cnt), 64'd0);
        cycle();
        chk("stall_resume", 64'(mem_req), 64'd1);
        drain(64'h200);

        // Overflow of requester 0 while the controller is stalled
        do_reset();
        mem_stall = 1'b1;
        for (int p = 0; p < 17; p++) begin
            pushv(4'b0001, p, 0, p < 16);
            if (p == 10) chk("afull_after_11", 64'(req_afull), 64'd0);
            if (p == 11) chk("afull_after_12", 64'(req_afull), 64'd1);
            if (p == 15) chk("err_after_16", 64'(err), 64'd0);
        end
        chk("err_after_17", 64'(err), 64'd1);
        mem_stall = 1'b0;
        drain(64'h300);
        chk("err_sticky", 64'(err), 64'd1);

        // Tag limit: 64 in flight, the 65th waits for a response
        do_reset();
        chk("reset_clears_err", 64'(err), 64'd0);
        for (int k = 0; k < 17; k++) pushv(4'hF, k, 0, 1'b1);
        repeat (60) cycle();
        chk("tag_inflight", 64'(inflight.size()), 64'd64);
        chk("tag_hold", 64'(mem_req), 64'd0);
        respond(64'h5000);
        chk("tag_release_c1", 64'(mem_req), 64'd0);
        cycle();
        chk("tag_release_c2", 64'(mem_req), 64'd1);
        drain(64'h6000);
        chk("orphan_err_pre", 64'(err), 64'd0);
        respond(64'hBAD);
        chk("orphan_no_rsp", 64'(rsp_push), 64'd0);
        chk("orphan_err", 64'(err), 64'd1);

        // Asynchronous reset in the middle of traffic
        pushv(4'b0011, 0, 0, 1'b1);
        pushv(4'b0011, 1, 0, 1'b1);
        chk("arst_pre_mem_req", 64'(mem_req), 64'd1);
        #2;
        rst = 1'b0;
        exp_iss.delete();
        inflight.delete();
        exp_rsp.delete();
        #1;
        chk("arst_mem_req", 64'(mem_req), 64'd0);
        chk("arst_mem_req_addr", 64'(mem_req_addr), 64'd0);
        chk("arst_rsp_push", 64'(rsp_push), 64'd0);
        chk("arst_rsp_q", rsp_q, 64'd0);
        chk("arst_req_afull", 64'(req_afull), 64'd0);
        chk("arst_idle", 64'(idle), 64'd1);
        chk("arst_err", 64'(err), 64'd0);
        cycle();
        rst = 1'b1;
        cycle();
        pushv(4'b1101, 7, 0, 1'b1);
        drain(64'h7000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
